// File: rtl/muldiv_unit.sv
// RV32M multiply/divide execute unit: a 2-cycle multiplier and a 32-iteration
// radix-2 restoring divider behind a single start/busy/done handshake.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV_ITER, S_DIV_FIN, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;        // multiplicand, or dividend shifting into quotient
    logic [XLEN-1:0] b_q, b_d;        // multiplier, or divisor magnitude
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

    logic            accept, is_signed, a_neg, b_neg;
    logic            a_sx, b_sx;
    logic signed [2*XLEN-1:0] mul_a, mul_b, prod;
    logic [XLEN-1:0] mul_sel, quo_fin, rem_fin;
    logic [XLEN:0]   rem_sh, trial;

    assign busy   = (state_q == S_MUL) || (state_q == S_DIV_ITER) || (state_q == S_DIV_FIN);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

    assign accept    = start && !busy && !flush && alu_control[3];
    assign is_signed = !alu_control[0];
    assign a_neg     = is_signed && op_a[XLEN-1];
    assign b_neg     = is_signed && op_b[XLEN-1];

    // Low 2*XLEN bits of the 33x33 signed product; the extension bit picks MUL/MULH/MULHSU/MULHU.
    assign a_sx    = (op_q != 2'b11) && a_q[XLEN-1];
    assign b_sx    = !op_q[1] && b_q[XLEN-1];
    assign mul_a   = {{XLEN{a_sx}}, a_q};
    assign mul_b   = {{XLEN{b_sx}}, b_q};
    assign prod    = mul_a * mul_b;
    assign mul_sel = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
    assign rem_sh  = {rem_q, a_q[XLEN-1]};
    assign trial   = rem_sh - {1'b0, b_q};
    assign quo_fin = neg_quo_q ? -a_q : a_q;
    assign rem_fin = neg_rem_q ? -rem_q : rem_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no branch can infer a latch.
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    op_d = alu_control[1:0];
                    if (!alu_control[2]) begin
                        a_d     = op_a;
                        b_d     = op_b;
                        state_d = S_MUL;
                    end else begin
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = S_DIV_FIN;
                        if (op_b == '0) begin
                            a_d   = '1;
                            rem_d = op_a;
                        end else if (is_signed && op_a == MIN_INT && op_b == '1) begin
                            a_d   = MIN_INT;
                            rem_d = '0;
                        end else begin
                            a_d       = a_neg ? -op_a : op_a;
                            b_d       = b_neg ? -op_b : op_b;
                            rem_d     = '0;
                            cnt_d     = CW'(XLEN);
                            neg_quo_d = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            state_d   = S_DIV_ITER;
                        end
                    end
                end
            end
            S_MUL: begin
                result_d = mul_sel;
                state_d  = S_DONE;
            end
            S_DIV_ITER: begin
                a_d   = {a_q[XLEN-2:0], !trial[XLEN]};
                rem_d = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = S_DIV_FIN;
            end
            S_DIV_FIN: begin
                result_d = op_q[1] ? rem_fin : quo_fin;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle RV32M execute unit downstream of the control unit.
- Consumes the 4-bit alu_control MULDIV codes 4'b1000 to 4'b1111 together with the two register operands.
- Multiply results are produced in a fixed 2 cycles; divide and remainder use a 32-iteration radix-2 restoring divider.
- busy is the pipeline stall request; done/result deliver the writeback value.

Parameters:
- XLEN, 32, operand and result width. Only 32 is supported; the iteration count equals XLEN.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only while busy=0.
- flush  in  1  synchronous abort of any in-flight operation.
- alu_control  in  4  operation code. 1000 MUL, 1001 MULH, 1010 MULHSU, 1011 MULHU, 1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU.
- op_a  in  XLEN  rs1 value (dividend / multiplicand).
- op_b  in  XLEN  rs2 value (divisor / multiplier).
- busy  out  1  operation in flight; the pipeline stalls while high.
- done  out  1  one-cycle pulse; result is valid in that cycle.
- result  out  XLEN  registered result; holds until the next done.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, busy=0, done=0, result=0, iteration counter=0.
  - Any in-flight operation is discarded with no done.
- States: IDLE, MUL, DIV_ITER, DIV_FIN, DONE.
- busy=1 in MUL, DIV_ITER and DIV_FIN. busy=0 in IDLE and DONE.
- done=1 only in DONE, which lasts exactly one cycle and then goes to IDLE unless a new start is accepted.
- Accept rule:
  - start=1, busy=0, flush=0 and alu_control[3]=1 → latch alu_control, op_a and op_b.
  - Accepting is legal in the DONE cycle, so back-to-back operations are supported.
  - start with alu_control[3]=0 is ignored.
  - start while busy=1 is ignored; inputs are not re-sampled.
- Multiply path (codes 1000 to 1011):
  - Accept → MUL.
  - Compute a 33x33 signed product. Operand extension: MUL/MULH sign-extend both operands; MULHSU sign-extends a and zero-extends b; MULHU zero-extends both.
  - MUL takes bits [31:0]; the others take [63:32].
  - Register the selected bits into result → DONE.
  - Start sampled in cycle 0 → done in cycle 2.
- Divide path (codes 1100 to 1111). Signed ops are DIV/REM; unsigned ops are DIVU/REMU.
  - On accept, check special cases first:
    - op_b=0: quotient=0xFFFFFFFF, remainder=op_a.
    - Signed op with op_a=0x80000000 and op_b=0xFFFFFFFF: quotient=0x80000000, remainder=0.
    - A special case goes directly to DIV_FIN, so done is in cycle 2.
  - Otherwise:
    - Latch absolute values (signed ops) or raw values (unsigned ops), set the quotient/remainder sign flags, counter=32 → DIV_ITER.
    - Each DIV_ITER cycle: shift {rem,quo} left by 1, trial-subtract the divisor, set the quotient LSB on no-borrow, decrement the counter.
    - Counter reaching 0 → DIV_FIN.
  - DIV_FIN:
    - Negate the quotient if sign(a) xor sign(b), signed ops only.
    - Negate the remainder if sign(a), signed ops only.
    - Select quotient (DIV/DIVU) or remainder (REM/REMU), register into result → DONE.
  - Normal divide: start in cycle 0 → done in cycle 34.
- Flush:
  - flush=1 in any state → IDLE next edge; done forced 0 that cycle, result unchanged.
  - flush has priority over start; simultaneous flush+start accepts nothing.
- Reset mid-operation: same as the reset values above; the first start after rst_n deasserts is accepted normally.
- Timing: no combinational path from any input to busy, done or result; all outputs are registered.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD (−3), start in cycle 0 → busy=1 in cycle 1, done=1 in cycle 2, result=0xFFFFFFEB.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. Each has done in cycle 2.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD, done in cycle 34, busy high cycles 1 to 33. REM of the same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Special cases:
  - DIVU 100/0 → 0xFFFFFFFF.
  - REMU 100/0 → 100.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
  - All four have done in cycle 2.
- Abort:
  - flush in cycle 10 of a DIV → busy=0 from cycle 11, no done pulse, result holds its previous value.
  - rst_n low in cycle 5 of a DIV → busy=0, done=0 and result=0 immediately (async).
- Handshake:
  - start with a DIVU while a DIV is busy → ignored; exactly one done occurs.
  - start of a MUL in the DIV's done cycle → the MUL is accepted and its done follows 2 cycles later.
  - start with alu_control=0000 → no busy, no done.
